// File: rtl/lfsr_encryptor_if.sv
// ----------------------------------------------------------------------------
// lfsr_encryptor_if
//   Memory bus between the encryptor and the shared 256x8 data memory.
//   The memory is a synchronous RAM: read data returns the cycle after the
//   read address is presented, and a write commits on the clock edge that
//   samples mem_wr_en high.
//
//   Signals:
//     mem_raddr  encryptor -> memory  read address
//     mem_rdata  memory -> encryptor  read data (one cycle after mem_raddr)
//     mem_wr_en  encryptor -> memory  write strobe
//     mem_waddr  encryptor -> memory  write address
//     mem_wdata  encryptor -> memory  write data
//
//   Modports: master = encryptor side, slave = memory side.
// ----------------------------------------------------------------------------
interface lfsr_encryptor_if;
    logic [7:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;

    modport master (
        output mem_raddr,
        output mem_wr_en,
        output mem_waddr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_raddr,
        input  mem_wr_en,
        input  mem_waddr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lfsr_encryptor.sv
// ----------------------------------------------------------------------------
// lfsr_encryptor
//   Builds a FRAME_LEN-byte frame (PAD_CHAR pre-pad, plaintext message read
//   from MSG_BASE, PAD_CHAR post-pad), XORs every frame byte with a 6-bit
//   LFSR stream and writes the ciphertext to CRYPTO_BASE.. in memory, then
//   holds done high until init is raised.
//
//   Optional build macro: ENC_PARITY_EN
//     defined   -> bit 7 of every written byte is the even parity of bits 6:0
//     undefined -> bit 7 is the frame byte's own bit 7
//
//   Ports:
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     init        high = hold idle / abort a run; a run starts on the first
//                 edge that samples it low
//     pat_sel     LFSR tap pattern select (sampled in LOAD)
//     lfsr_init   LFSR seed (sampled in LOAD)
//     pre_length  pre-pad byte count (sampled in LOAD)
//     msg_len     plaintext byte count (sampled in LOAD)
//     mem         memory bus (master side), see lfsr_encryptor_if
//     done        run complete, held until init goes high
//     dbg_state   current FSM state, for observation only
//
//   Handshake: init low starts a run; done high means all FRAME_LEN bytes
//   have been written; done stays high while init stays low and clears on
//   the edge after init is sampled high.
// ----------------------------------------------------------------------------
module lfsr_encryptor #(
    parameter logic [7:0] MSG_BASE    = 8'd0,
    parameter logic [7:0] CRYPTO_BASE = 8'd64,
    parameter int         FRAME_LEN   = 64,
    parameter logic [7:0] PAD_CHAR    = 8'h5F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic [2:0]       pat_sel,
    input  logic [5:0]       lfsr_init,
    input  logic [7:0]       pre_length,
    input  logic [6:0]       msg_len,
    lfsr_encryptor_if.master mem,
    output logic             done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAD   = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] FRAME_LEN_B = 8'(FRAME_LEN);
    localparam logic [6:0] LAST_IDX    = 7'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic [5:0] lfsr_q, lfsr_d;
    logic [6:0] i_q, i_d;
    logic [7:0] pre_q, pre_d;
    logic [7:0] m_q, m_d;
    logic [5:0] taps_q, taps_d;

    logic [7:0] m_load;
    logic [7:0] room;
    logic [6:0] i_next;
    logic       adv;

    logic [7:0] raddr;
    logic       wr_en;
    logic [7:0] waddr;
    logic [7:0] wdata_raw;
    logic [7:0] wdata;
    logic       done_c;

    function automatic logic [5:0] taps_of(input logic [2:0] sel);
        case (sel)
            3'd0:    taps_of = 6'h21;
            3'd1:    taps_of = 6'h2D;
            3'd2:    taps_of = 6'h30;
            3'd3:    taps_of = 6'h33;
            3'd4:    taps_of = 6'h36;
            3'd5:    taps_of = 6'h39;
            default: taps_of = 6'h21;
        endcase
    endfunction

    // Frame byte idx comes from the message when pre <= idx < pre + m.
    // 9-bit compare so pre + m can never wrap.
    function automatic logic is_msg(input logic [6:0] idx,
                                    input logic [7:0] pre,
                                    input logic [7:0] m);
        logic [8:0] idx_w;
        logic [8:0] lo;
        logic [8:0] hi;
        idx_w  = {2'b00, idx};
        lo     = {1'b0, pre};
        hi     = {1'b0, pre} + {1'b0, m};
        is_msg = (idx_w >= lo) && (idx_w < hi);
    endfunction

    // Message bytes that actually fit after the pre-pad.
    always_comb begin
        room = FRAME_LEN_B - pre_length;
        if (pre_length >= FRAME_LEN_B) begin
            m_load = '0;
        end else if ({1'b0, msg_len} < room) begin
            m_load = {1'b0, msg_len};
        end else begin
            m_load = room;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        i_d       = i_q;
        pre_d     = pre_q;
        m_d       = m_q;
        taps_d    = taps_q;
        raddr     = '0;
        wr_en     = 1'b0;
        waddr     = '0;
        wdata_raw = '0;
        done_c    = 1'b0;
        adv       = 1'b0;
        i_next    = i_q + 7'd1;

        case (state_q)
            S_IDLE: begin
                if (!init) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (init) begin
                    state_d = S_IDLE;
                end else begin
                    taps_d  = taps_of(pat_sel);
                    pre_d   = pre_length;
                    m_d     = m_load;
                    lfsr_d  = lfsr_init;
                    i_d     = '0;
                    // First byte decided from the values being latched now.
                    state_d = is_msg(7'd0, pre_length, m_load) ? S_READ : S_PAD;
                end
            end

            S_PAD: begin
                wr_en     = 1'b1;
                waddr     = CRYPTO_BASE + {1'b0, i_q};
                wdata_raw = PAD_CHAR ^ {2'b00, lfsr_q};
                if (init) begin
                    state_d = S_IDLE;
                end else begin
                    adv = 1'b1;
                end
            end

            S_READ: begin
                raddr = MSG_BASE + ({1'b0, i_q} - pre_q);
                if (init) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                wr_en     = 1'b1;
                waddr     = CRYPTO_BASE + {1'b0, i_q};
                wdata_raw = mem.mem_rdata ^ {2'b00, lfsr_q};
                if (init) begin
                    state_d = S_IDLE;
                end else begin
                    adv = 1'b1;
                end
            end

            S_DONE: begin
                done_c = 1'b1;
                if (init) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte was written this cycle: step the stream and pick the next
        // byte's path, or finish after the last frame index.
        if (adv) begin
            lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
            i_d    = i_next;
            if (i_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                state_d = is_msg(i_next, pre_q, m_q) ? S_READ : S_PAD;
            end
        end
    end

`ifdef ENC_PARITY_EN
    assign wdata = {^wdata_raw[6:0], wdata_raw[6:0]};
`else
    assign wdata = wdata_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            i_q     <= '0;
            pre_q   <= '0;
            m_q     <= '0;
            taps_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
            pre_q   <= pre_d;
            m_q     <= m_d;
            taps_q  <= taps_d;
        end
    end

    assign mem.mem_raddr = raddr;
    assign mem.mem_wr_en = wr_en;
    assign mem.mem_waddr = waddr;
    assign mem.mem_wdata = wdata;
    assign done          = done_c;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lfsr_encryptor.sv
// ----------------------------------------------------------------------------
// tb_lfsr_encryptor
//   Bench for lfsr_encryptor: a 256x8 synchronous memory model, a frame-level
//   model that precomputes the expected write sequence of a run, a compare
//   process that checks every write cycle, and directed runs with literal
//   expectations taken by hand from the frame/stream rules.
// ----------------------------------------------------------------------------
module tb_lfsr_encryptor;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b1;
    logic [2:0] pat_sel = '0;
    logic [5:0] lfsr_init = '0;
    logic [7:0] pre_length = '0;
    logic [6:0] msg_len = '0;
    logic       done;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    lfsr_encryptor_if bus ();

    lfsr_encryptor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .pat_sel    (pat_sel),
        .lfsr_init  (lfsr_init),
        .pre_length (pre_length),
        .msg_len    (msg_len),
        .mem        (bus),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_raddr];
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    // {is_msg, expected read addr, write addr, write data}
    logic [24:0] exp_q[$];
    logic [24:0] e_cur;
    logic [7:0]  prev_raddr = '0;
    logic [7:0]  frame_m  [0:63];
    logic [5:0]  stream_m [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [5:0] taps_of(input logic [2:0] p);
        logic [5:0] tbl [0:7];
        tbl = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39, 6'h21, 6'h21};
        return tbl[p];
    endfunction

    // Whole-frame model: message length after truncation, the key stream,
    // the plaintext frame, and the resulting write sequence.
    task automatic build_model(input logic [2:0] p, input logic [5:0] seed,
                               input logic [7:0] pre, input logic [6:0] len,
                               output int m);
        int pre_i;
        int len_i;
        logic [5:0] s;
        logic [5:0] t;
        logic [7:0] c;
        logic       is_m;
        pre_i = int'(pre);
        len_i = int'(len);
        if (pre_i >= 64) m = 0;
        else m = (len_i < 64 - pre_i) ? len_i : 64 - pre_i;
        s = seed;
        t = taps_of(p);
        for (int k = 0; k < 64; k++) begin
            stream_m[k] = s;
            s = {s[4:0], ^(s & t)};
        end
        for (int k = 0; k < 64; k++) begin
            is_m = (k >= pre_i) && (k < pre_i + m);
            frame_m[k] = is_m ? mem[k - pre_i] : 8'h5F;
            c = frame_m[k] ^ {2'b00, stream_m[k]};
`ifdef ENC_PARITY_EN
            c[7] = ^c[6:0];
`endif
            exp_q.push_back({is_m, 8'(k - pre_i), 8'(64 + k), c});
        end
    endtask

    // Compare process: every write must match the next expected write; a
    // message write must be preceded by a read of the right plaintext byte.
    always @(negedge clk) begin
        if (rst_n && bus.mem_wr_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none",
                         bus.mem_waddr, bus.mem_wdata);
            end else begin
                e_cur = exp_q.pop_front();
                check("write_addr", {24'd0, bus.mem_waddr}, {24'd0, e_cur[15:8]});
                check("write_data", {24'd0, bus.mem_wdata}, {24'd0, e_cur[7:0]});
                if (e_cur[24]) check("read_addr", {24'd0, prev_raddr}, {24'd0, e_cur[23:16]});
            end
        end
        prev_raddr = bus.mem_raddr;
    end

    // ---------------- driver tasks ----------------
    // Returns to IDLE, applies the config, starts the run and leaves the
    // caller just after edge 0 (the edge sampling init low).
    task automatic start_run(input logic [2:0] p, input logic [5:0] s,
                             input logic [7:0] pre, input logic [6:0] len, output int m);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        pat_sel    = p;
        lfsr_init  = s;
        pre_length = pre;
        msg_len    = len;
        exp_q.delete();
        build_model(p, s, pre, len, m);
        init = 1'b0;
        @(posedge clk);
    endtask

    task automatic scramble_cfg();
        pat_sel    = 3'($urandom_range(0, 7));
        lfsr_init  = 6'($urandom_range(0, 63));
        pre_length = 8'($urandom_range(0, 255));
        msg_len    = 7'($urandom_range(0, 127));
    endtask

    task automatic run_frame(input string name, input logic [2:0] p, input logic [5:0] s,
                             input logic [7:0] pre, input logic [6:0] len);
        int m;
        int k;
        bit got;
        start_run(p, s, pre, len, m);
        got = 1'b0;
        k = 0;
        while (!got && k < 300) begin
            @(posedge clk);
            #1;
            k++;
            // Config has been latched on edge 1; later changes must not matter.
            if (k == 1) scramble_cfg();
            if (done) begin
                got = 1'b1;
                check({name, "_latency"}, k, 65 + m);
            end
        end
        if (!got) check({name, "_done_timeout"}, {31'd0, done}, 32'd1);
        check({name, "_all_written"}, exp_q.size(), 0);
    endtask

    task automatic wait_edges(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    int m_tmp;

    initial begin
        for (int a = 0; a < 256; a++) begin
            if (a < 64) mem[a] <= 8'((a * 7 + 8'h11) & 8'h7F);
            else        mem[a] <= 8'hAA;
        end
        #1;
        mem[0] <= 8'h41;
        mem[1] <= 8'h42;
        mem[2] <= 8'h43;
        mem[3] <= 8'h44;

        // Reset state
        #1;
        check("rst_done",      {31'd0, done},           32'd0);
        check("rst_wr_en",     {31'd0, bus.mem_wr_en},  32'd0);
        check("rst_raddr",     {24'd0, bus.mem_raddr},  32'd0);
        check("rst_waddr",     {24'd0, bus.mem_waddr},  32'd0);
        check("rst_wdata",     {24'd0, bus.mem_wdata},  32'd0);
        check("rst_state",     {29'd0, dbg_state},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(3);
        check("idle_hold_done", {31'd0, done}, 32'd0);

        // Pad only
        run_frame("pad_only", 3'd0, 6'h01, 8'd10, 7'd0);
`ifdef ENC_PARITY_EN
        check("pad_mem64", {24'd0, mem[64]}, 32'hDE);
        check("pad_mem65", {24'd0, mem[65]}, 32'h5C);
        check("pad_mem66", {24'd0, mem[66]}, 32'hD8);
`else
        check("pad_mem64", {24'd0, mem[64]}, 32'h5E);
        check("pad_mem65", {24'd0, mem[65]}, 32'h5C);
        check("pad_mem66", {24'd0, mem[66]}, 32'h58);
`endif

        // Message "ABCD" at pre-pad 8; stream states 8..11 are 38,30,20,01
        run_frame("msg_abcd", 3'd2, 6'h15, 8'd8, 7'd4);
`ifdef ENC_PARITY_EN
        check("msg_mem72", {24'd0, mem[72]}, 32'hF9);
        check("msg_mem73", {24'd0, mem[73]}, 32'h72);
        check("msg_mem74", {24'd0, mem[74]}, 32'h63);
        check("msg_mem75", {24'd0, mem[75]}, 32'hC5);
`else
        check("msg_mem72", {24'd0, mem[72]}, 32'h79);
        check("msg_mem73", {24'd0, mem[73]}, 32'h72);
        check("msg_mem74", {24'd0, mem[74]}, 32'h63);
        check("msg_mem75", {24'd0, mem[75]}, 32'h45);
`endif
        check("model_stream8",  {26'd0, stream_m[8]},  32'h38);
        check("model_stream11", {26'd0, stream_m[11]}, 32'h01);
        for (int k = 0; k < 64; k++) begin
            check("msg_roundtrip", {24'd0, (mem[64 + k] ^ {2'b00, stream_m[k]}) & 8'h7F},
                  {24'd0, frame_m[k] & 8'h7F});
        end

        // Truncation, pre-pad past the frame, all-zero seed
        run_frame("trunc", 3'd5, 6'h2A, 8'd60, 7'd10);
        run_frame("pre_over", 3'd7, 6'h11, 8'd70, 7'd5);
        run_frame("zero_seed", 3'd3, 6'h00, 8'd2, 7'd20);
        check("zero_mem64",  {24'd0, mem[64]},  32'h5F);
        check("zero_mem66",  {24'd0, mem[66]},  32'h41);
        check("zero_mem127", {24'd0, mem[127]}, 32'h5F);

        // Abort with init on edge 20 of a pad-only run
        start_run(3'd1, 6'h2B, 8'd64, 7'd0, m_tmp);
        wait_edges(20);
        check("abort_wr_before", {31'd0, bus.mem_wr_en}, 32'd1);
        init = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        check("abort_done",  {31'd0, done},          32'd0);
        check("abort_state", {29'd0, dbg_state},     32'd0);
        exp_q.delete();

        // Asynchronous reset mid-run
        start_run(3'd4, 6'h07, 8'd70, 7'd0, m_tmp);
        wait_edges(10);
        check("rstmid_wr_before", {31'd0, bus.mem_wr_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        check("rstmid_waddr", {24'd0, bus.mem_waddr}, 32'd0);
        check("rstmid_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        check("rstmid_done",  {31'd0, done},          32'd0);
        check("rstmid_state", {29'd0, dbg_state},     32'd0);
        init = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();

        // Handshake: done held while init stays low, no further writes
        run_frame("full_msg", 3'd4, 6'h3F, 8'd0, 7'd64);
        for (int j = 0; j < 100; j++) begin
            @(posedge clk);
            #1;
            check("done_hold", {31'd0, done}, 32'd1);
        end
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        check("done_clear", {31'd0, done}, 32'd0);
        run_frame("rerun", 3'd1, 6'h0B, 8'd30, 7'd40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog actual=running required=finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
